// File: rtl/accel_pkg.sv
// Shared types and widths for the accelerator memory responder.
package accel_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/accel_word_ram.sv
// Single-port word RAM: synchronous write, asynchronous read, contents never reset.
module accel_word_ram
  import accel_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/accel_mem_responder.sv
// Memory-mapped word store answering an accelerator master with programmable
// wait states, sticky error reporting and saturating transfer counters.
module accel_mem_responder
  import accel_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [DATA_W-1:0] slave_writedata,
  output logic [DATA_W-1:0] slave_readdata,
  output logic              slave_waitrequest,
  output logic              err,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [AW-1:0]     word_q, word_d;
  logic              wr_q, wr_d;
  logic              oor_q, oor_d;
  logic              conflict_q, conflict_d;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q;
  logic              err_q;

  logic [29:0]       req_word;
  logic              req_oor, req_valid, req_held;
  logic              ack_rd, ack_wr, ram_we;
  logic [DATA_W-1:0] ram_rdata, ack_rdata;

  // BASE is assumed word aligned, so the index is a plain word-address difference.
  assign req_word  = slave_address[31:2] - BASE[31:2];
  assign req_oor   = (slave_address < BASE) || ({2'b00, req_word} >= 32'(DEPTH));
  assign req_valid = slave_read | slave_write;
  assign req_held  = wr_q ? slave_write : slave_read;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    word_d     = word_q;
    wr_d       = wr_q;
    oor_d      = oor_q;
    conflict_d = conflict_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          word_d     = req_word[AW-1:0];
          wr_d       = slave_write;
          oor_d      = req_oor;
          conflict_d = slave_read & slave_write;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            wcnt_d  = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = ACK;
          end
        end
      end
      WAIT: begin
        if (!req_held) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ack_rd    = (state_q == ACK) && !wr_q;
  assign ack_wr    = (state_q == ACK) && wr_q;
  assign ram_we    = ack_wr && !oor_q;
  assign ack_rdata = oor_q ? '0 : ram_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      word_q     <= '0;
      wr_q       <= 1'b0;
      oor_q      <= 1'b0;
      conflict_q <= 1'b0;
      rdata_q    <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      word_q     <= word_d;
      wr_q       <= wr_d;
      oor_q      <= oor_d;
      conflict_q <= conflict_d;
      if (ack_rd) begin
        rdata_q  <= ack_rdata;
        rd_cnt_q <= sat_inc(rd_cnt_q);
      end
      if (ack_wr) begin
        wr_cnt_q <= sat_inc(wr_cnt_q);
      end
      if ((state_q == ACK) && (oor_q || conflict_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  accel_word_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (word_q),
    .wdata(slave_writedata),
    .rdata(ram_rdata)
  );

  // Read data is live during ACK and held in rdata_q afterwards.
  assign slave_readdata    = ack_rd ? ack_rdata : rdata_q;
  assign slave_waitrequest = (state_q != ACK);
  assign err               = err_q;
  assign rd_count          = rd_cnt_q;
  assign wr_count          = wr_cnt_q;

endmodule

// File: tb/tb_accel_mem_responder.sv
// Directed bench: instance A (BASE 0x1000, one wait state), instance B (BASE 0, no wait states).
module tb_accel_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  logic        a_rd, a_wr, a_wait, a_err, b_rd, b_wr, b_wait, b_err;
  logic [15:0] a_rdc, a_wrc, b_rdc, b_wrc;
  int          testsRun = 0;
  int          testsFailed = 0;

  always #5 clk = ~clk;

  accel_mem_responder #(.DEPTH(16), .BASE(32'h0000_1000), .WAIT_CYCLES(1)) dutA (
    .clk(clk), .reset(reset), .slave_address(a_addr), .slave_read(a_rd),
    .slave_write(a_wr), .slave_writedata(a_wdata), .slave_readdata(a_rdata),
    .slave_waitrequest(a_wait), .err(a_err), .rd_count(a_rdc), .wr_count(a_wrc)
  );

  accel_mem_responder #(.DEPTH(16), .BASE(32'h0000_0000), .WAIT_CYCLES(0)) dutB (
    .clk(clk), .reset(reset), .slave_address(b_addr), .slave_read(b_rd),
    .slave_write(b_wr), .slave_writedata(b_wdata), .slave_readdata(b_rdata),
    .slave_waitrequest(b_wait), .err(b_err), .rd_count(b_rdc), .wr_count(b_wrc)
  );

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel) begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = data;
    end else begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = data;
    end
  endtask

  function automatic logic get_wait(input bit sel);
    return sel ? b_wait : a_wait;
  endfunction

  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? b_rdata : a_rdata;
  endfunction

  // One full transfer; cycles counts from the first request cycle to the ACK cycle.
  task automatic xfer(input bit sel, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data,
                      output int cycles, output logic [31:0] ackData);
    @(negedge clk);
    drive(sel, rd, wr, addr, data);
    cycles = 1;
    #1;
    while (get_wait(sel) && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    ackData = get_rdata(sel);
    drive(sel, 1'b0, 1'b0, addr, data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    testsRun++; if (a_wait !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_wait: got %b expected 1", a_wait); end
    testsRun++; if (a_rdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_rdata: got %h expected 0", a_rdata); end
    testsRun++; if (a_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %b expected 0", a_err); end
    testsRun++; if (a_rdc !== 16'd0 || a_wrc !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", a_rdc, a_wrc); end
    testsRun++; if (b_wait !== 1'b1 || b_rdc !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_b: got wait %b rd %0d expected 1/0", b_wait, b_rdc); end
    reset = 1'b1;
  endtask

  task automatic test_write();
    int cyc; logic [31:0] d;
    xfer(1'b0, 1'b0, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, cyc, d);
    testsRun++; if (cyc != 3) begin testsFailed++; $display("[TB] FAIL write_latency: got %0d expected 3", cyc); end
    testsRun++; if (a_wrc !== 16'd1) begin testsFailed++; $display("[TB] FAIL write_count: got %0d expected 1", a_wrc); end
    testsRun++; if (a_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL write_err: got %b expected 0", a_err); end
  endtask

  task automatic test_read();
    int cyc; logic [31:0] d;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_1008, 32'h0, cyc, d);
    testsRun++; if (d !== 32'hDEAD_BEEF) begin testsFailed++; $display("[TB] FAIL read_aligned: got %h expected deadbeef", d); end
    testsRun++; if (cyc != 3) begin testsFailed++; $display("[TB] FAIL read_latency: got %0d expected 3", cyc); end
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_1009, 32'h0, cyc, d);
    testsRun++; if (d !== 32'hDEAD_BEEF) begin testsFailed++; $display("[TB] FAIL read_unaligned: got %h expected deadbeef", d); end
    testsRun++; if (a_rdc !== 16'd2) begin testsFailed++; $display("[TB] FAIL read_count: got %0d expected 2", a_rdc); end
    repeat (2) @(negedge clk);
    testsRun++; if (a_rdata !== 32'hDEAD_BEEF) begin testsFailed++; $display("[TB] FAIL read_hold: got %h expected deadbeef", a_rdata); end
  endtask

  task automatic test_drop();
    int cyc; logic [31:0] d;
    xfer(1'b0, 1'b0, 1'b1, 32'h0000_100C, 32'hAAAA_0001, cyc, d);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_100C, 32'h0000_1234);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0000_100C, 32'h0000_1234);
    repeat (2) @(negedge clk);
    testsRun++; if (a_wait !== 1'b1) begin testsFailed++; $display("[TB] FAIL drop_wait: got %b expected 1", a_wait); end
    testsRun++; if (a_wrc !== 16'd2 || a_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL drop_count_err: got %0d/%b expected 2/0", a_wrc, a_err); end
    testsRun++; if (a_rdata !== 32'hDEAD_BEEF) begin testsFailed++; $display("[TB] FAIL drop_rdata_hold: got %h expected deadbeef", a_rdata); end
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_100C, 32'h0, cyc, d);
    testsRun++; if (d !== 32'hAAAA_0001) begin testsFailed++; $display("[TB] FAIL drop_ram: got %h expected aaaa0001", d); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [31:0] d;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_100C, 32'h0000_5555);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0000_100C, 32'h0000_5555);
    #1;
    testsRun++; if (a_wait !== 1'b1 || a_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_wait_err: got %b/%b expected 1/0", a_wait, a_err); end
    testsRun++; if (a_rdata !== 32'h0 || a_rdc !== 16'd0 || a_wrc !== 16'd0) begin testsFailed++; $display("[TB] FAIL midreset_outputs: got %h %0d %0d expected 0 0 0", a_rdata, a_rdc, a_wrc); end
    @(negedge clk);
    reset = 1'b1;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_100C, 32'h0, cyc, d);
    testsRun++; if (d !== 32'hAAAA_0001) begin testsFailed++; $display("[TB] FAIL midreset_ram: got %h expected aaaa0001", d); end
    testsRun++; if (cyc != 3 || a_rdc !== 16'd1) begin testsFailed++; $display("[TB] FAIL midreset_next: got %0d cycles rd %0d expected 3/1", cyc, a_rdc); end
  endtask

  task automatic test_out_of_range();
    int cyc; logic [31:0] d;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_1040, 32'h0, cyc, d);
    testsRun++; if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL oor_rdata: got %h expected 0", d); end
    testsRun++; if (a_err !== 1'b1 || a_rdc !== 16'd2) begin testsFailed++; $display("[TB] FAIL oor_err_count: got %b/%0d expected 1/2", a_err, a_rdc); end
    xfer(1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0BAD_F00D, cyc, d);
    testsRun++; if (a_err !== 1'b1 || a_wrc !== 16'd1) begin testsFailed++; $display("[TB] FAIL oor_sticky: got %b/%0d expected 1/1", a_err, a_wrc); end
    xfer(1'b0, 1'b0, 1'b1, 32'h0000_1040, 32'h0000_0099, cyc, d);
    testsRun++; if (cyc != 3 || a_wrc !== 16'd2) begin testsFailed++; $display("[TB] FAIL oor_write_complete: got %0d cycles wr %0d expected 3/2", cyc, a_wrc); end
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, cyc, d);
    testsRun++; if (d !== 32'h0BAD_F00D) begin testsFailed++; $display("[TB] FAIL oor_write_ram: got %h expected 0badf00d", d); end
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0, cyc, d);
    testsRun++; if (d !== 32'h0 || a_rdc !== 16'd4) begin testsFailed++; $display("[TB] FAIL below_base: got %h rd %0d expected 0/4", d, a_rdc); end
  endtask

  task automatic test_conflict();
    int cyc; logic [31:0] d;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    testsRun++; if (a_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_reset_clear: got %b expected 0", a_err); end
    xfer(1'b0, 1'b1, 1'b1, 32'h0000_1014, 32'h0000_0005, cyc, d);
    testsRun++; if (a_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL conflict_err: got %b expected 1", a_err); end
    testsRun++; if (a_rdc !== 16'd0 || a_wrc !== 16'd1) begin testsFailed++; $display("[TB] FAIL conflict_counts: got %0d/%0d expected 0/1", a_rdc, a_wrc); end
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_1014, 32'h0, cyc, d);
    testsRun++; if (d !== 32'h0000_0005) begin testsFailed++; $display("[TB] FAIL conflict_ram: got %h expected 5", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tab [9];
    int cyc, cycle, acks, lastAck;
    logic [31:0] d;
    tab = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003, 32'h5555_0004,
            32'h6666_0005, 32'h7777_0006, 32'h8888_0007, 32'h9999_0008};
    for (int i = 0; i < 9; i++) begin
      xfer(1'b1, 1'b0, 1'b1, 32'(4 * i), tab[i], cyc, d);
      if (i == 0) begin
        testsRun++; if (cyc != 2) begin testsFailed++; $display("[TB] FAIL b2b_write_latency: got %0d expected 2", cyc); end
      end
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    cycle = 1; acks = 0; lastAck = 0;
    while (acks < 9 && cycle < 100) begin
      #1;
      if (!b_wait) begin
        testsRun++; if (b_rdata !== tab[acks]) begin testsFailed++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", acks, b_rdata, tab[acks]); end
        testsRun++; if (cycle != 2 * (acks + 1)) begin testsFailed++; $display("[TB] FAIL b2b_cycle%0d: got %0d expected %0d", acks, cycle, 2 * (acks + 1)); end
        acks++;
        lastAck = cycle;
        b_addr = 32'(4 * acks);
        if (acks == 9) b_rd = 1'b0;
      end
      @(negedge clk);
      cycle++;
    end
    testsRun++; if (acks != 9 || lastAck != 18) begin testsFailed++; $display("[TB] FAIL b2b_total: got %0d acks in %0d cycles expected 9 in 18", acks, lastAck); end
    testsRun++; if (b_rdc !== 16'd9 || b_wrc !== 16'd9 || b_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_counts: got rd %0d wr %0d err %b expected 9 9 0", b_rdc, b_wrc, b_err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_drop();
    test_reset_mid();
    test_out_of_range();
    test_conflict();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/accel_mem_responder.md
ACCEL_MEM_RESPONDER -- requirements
Module: accel_mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words stored.
REQ-002 The module SHALL have parameter BASE, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 The module SHALL have parameter WAIT_CYCLES, default 1, meaning extra wait states per transfer, range 0..15.
REQ-004 The module SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-006 The module SHALL have port slave_address, input, 32, meaning byte address from the accelerator master.
REQ-007 The module SHALL have port slave_read, input, 1, meaning read request, held by the master until accepted.
REQ-008 The module SHALL have port slave_write, input, 1, meaning write request, held by the master until accepted.
REQ-009 The module SHALL have port slave_writedata, input, 32, meaning write data.
REQ-010 The module SHALL have port slave_readdata, output, 32, meaning read data.
REQ-011 The module SHALL have port slave_waitrequest, output, 1, meaning high = transfer not yet accepted.
REQ-012 The module SHALL have port err, output, 1, meaning sticky error flag.
REQ-013 The module SHALL have port rd_count, output, 16, meaning number of completed reads.
REQ-014 The module SHALL have port wr_count, output, 16, meaning number of completed writes.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, and ACK.
REQ-016 slave_waitrequest SHALL be low only in ACK and high in all other states.
REQ-017 In IDLE, if slave_read or slave_write is high, the block SHALL latch the address and the op, then enter WAIT if WAIT_CYCLES>0, otherwise ACK.
REQ-018 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-019 WAIT SHALL last exactly WAIT_CYCLES cycles, timed by a 4-bit down-counter, and then go to ACK.
REQ-020 A transfer SHALL take WAIT_CYCLES+2 cycles from first request cycle to completion; the completion cycle is the ACK cycle.
REQ-021 ACK SHALL always return to IDLE, giving a one-cycle bubble between back-to-back transfers.
REQ-022 The word index SHALL be (slave_address-BASE)>>2, and address bits [1:0] SHALL be ignored.
REQ-023 A read SHALL present the RAM word on slave_readdata during the ACK cycle.
REQ-024 slave_readdata SHALL hold that word until the next read completes.
REQ-025 A write SHALL commit slave_writedata (sampled during the ACK cycle) to RAM at the ACK clock edge.
REQ-026 If slave_read and slave_write are both high in IDLE, the write SHALL take priority, the read SHALL be dropped, and err SHALL be set.
REQ-027 An out-of-range address (below BASE, or index >= DEPTH) on a read SHALL complete normally with slave_readdata = 0 and set err.
REQ-028 An out-of-range write SHALL complete normally, leave the RAM unchanged, and set err.
REQ-029 If the master drops its request before ACK, the FSM SHALL return to IDLE with no RAM access, no count change, and no error.
REQ-030 rd_count and wr_count SHALL increment in the ACK cycle, including out-of-range accesses, and saturate at 16'hFFFF.
REQ-031 err SHALL be cleared only by reset.

Reset
REQ-032 When reset is low, the FSM SHALL go to IDLE, slave_waitrequest=1, slave_readdata=0, err=0, rd_count=0, wr_count=0, and the wait counter=0.
REQ-033 A reset in mid-transfer SHALL abort it with no RAM write.
REQ-034 RAM contents SHALL NOT be reset.

Structure
REQ-035 The FSM state encoding, the data width of 32, and the counter width of 16 SHALL be placed in shared package accel_pkg.
REQ-036 Storage SHALL be the sub-module accel_word_ram: single-port, synchronous write, asynchronous read, DEPTH x 32.

Verification
REQ-037 Reset, then write 32'hDEADBEEF to BASE+8 with WAIT_CYCLES=1 -> waitrequest low on cycle 3, wr_count=1, err=0.
REQ-038 Read BASE+8, then BASE+9 -> both return 32'hDEADBEEF at the ACK cycle, rd_count=2.
REQ-039 With WAIT_CYCLES=0, run 9 back-to-back reads -> each completes in 2 cycles, 18 cycles total.
REQ-040 Read at BASE+4*DEPTH -> readdata 0 and err=1; a following in-range write SHALL leave err=1.
REQ-041 Assert slave_read and slave_write together with data 32'h5 -> RAM updated, rd_count unchanged, err=1.
REQ-042 Assert reset during WAIT of a write -> no RAM change, all outputs at reset values, next transfer normal.
